// File: rtl/fetch_pc_ctrl.sv
// Instruction fetch PC controller: back-to-back fetch, one-entry skid on stall,
// redirect with drain of an unacked request. Outputs registered, one cycle after ack.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hazard_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instrn_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        flush_out
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] skid_instrn;
    logic [31:0] skid_pc;
    logic        skid_vld;
    logic        redirect;
    logic        loadable;
    logic [31:0] target;

    assign redirect = (trap_in || branch_taken_in) && (state != IDLE);
    assign target   = trap_in ? TRAP_VECTOR : (branch_target_in & 32'hFFFF_FFFC);
    assign loadable = !hazard_in || !valid_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem_req_out  = 1'b0;
        imem_addr_out = 32'h0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req_out  = 1'b1;
                imem_addr_out = pc;
                if (redirect) begin
                    state_nxt = imem_ack_in ? FETCH : DRAIN;
                end else if (imem_ack_in && !loadable) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect || loadable) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                // The in-flight address stays on the bus until memory answers.
                imem_req_out  = 1'b1;
                imem_addr_out = drain_addr;
                if (imem_ack_in) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= RESET_VECTOR;
            drain_addr  <= 32'h0;
            skid_instrn <= 32'h0;
            skid_pc     <= 32'h0;
            skid_vld    <= 1'b0;
            instrn_out  <= 32'h0;
            pc_out      <= 32'h0;
            valid_out   <= 1'b0;
            flush_out   <= 1'b0;
        end else begin
            flush_out <= redirect;
            if (redirect) begin
                pc         <= target;
                instrn_out <= 32'h0;
                pc_out     <= 32'h0;
                valid_out  <= 1'b0;
                skid_vld   <= 1'b0;
                if (state == FETCH) begin
                    drain_addr <= pc;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_ack_in) begin
                            pc <= pc + 32'd4;
                            if (loadable) begin
                                instrn_out <= imem_rdata_in;
                                pc_out     <= pc;
                                valid_out  <= 1'b1;
                            end else begin
                                skid_instrn <= imem_rdata_in;
                                skid_pc     <= pc;
                                skid_vld    <= 1'b1;
                            end
                        end else if (loadable) begin
                            instrn_out <= 32'h0;
                            pc_out     <= 32'h0;
                            valid_out  <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (loadable) begin
                            instrn_out <= skid_instrn;
                            pc_out     <= skid_pc;
                            valid_out  <= skid_vld;
                            skid_vld   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed vector bench for fetch_pc_ctrl: table of per-cycle stimulus and
// hand-computed post-edge outputs, followed by wrap and reset-during-drain sequences.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hazard_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        trap_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instrn_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        flush_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .hazard_in        (hazard_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .trap_in          (trap_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ack_in      (imem_ack_in),
        .imem_rdata_in    (imem_rdata_in),
        .instrn_out       (instrn_out),
        .pc_out           (pc_out),
        .valid_out        (valid_out),
        .flush_out        (flush_out)
    );

    typedef struct {
        logic        rst_n;
        logic        haz;
        logic        br;
        logic        trap;
        logic        ack;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic haz, input logic br, input logic trap,
                       input logic ack, input logic [31:0] tgt, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic e_vld, input logic e_flush);
        vec_t v;
        v.rst_n = rst_n; v.haz = haz; v.br = br; v.trap = trap; v.ack = ack;
        v.tgt = tgt; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_vld = e_vld; v.e_flush = e_flush;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input string name);
        reset_n          = v.rst_n;
        hazard_in        = v.haz;
        branch_taken_in  = v.br;
        trap_in          = v.trap;
        imem_ack_in      = v.ack;
        branch_target_in = v.tgt;
        imem_rdata_in    = v.rdata;
        @(posedge clk);
        #1;
        tests++;
        if (imem_req_out !== v.e_req || imem_addr_out !== v.e_addr || instrn_out !== v.e_instr ||
            pc_out !== v.e_pc || valid_out !== v.e_vld || flush_out !== v.e_flush) begin
            fails++;
            $display("FAIL %s: got req=%b addr=%h instr=%h pc=%h vld=%b flush=%b, want req=%b addr=%h instr=%h pc=%h vld=%b flush=%b",
                     name, imem_req_out, imem_addr_out, instrn_out, pc_out, valid_out, flush_out,
                     v.e_req, v.e_addr, v.e_instr, v.e_pc, v.e_vld, v.e_flush);
        end
    endtask

    task automatic seq(input logic rst_n, input logic br, input logic ack, input logic [31:0] tgt,
                       input logic [31:0] rdata, input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_vld,
                       input logic e_flush, input string name);
        vec_t v;
        v.rst_n = rst_n; v.haz = 1'b0; v.br = br; v.trap = 1'b0; v.ack = ack;
        v.tgt = tgt; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_vld = e_vld; v.e_flush = e_flush;
        step(v, name);
    endtask

    initial begin
        reset_n = 1'b0; hazard_in = 1'b0; branch_taken_in = 1'b0; trap_in = 1'b0;
        imem_ack_in = 1'b0; branch_target_in = 32'h0; imem_rdata_in = 32'h0;

        //   rst haz br tr ack tgt           rdata                req addr          instr               pc            v  fl
        add(0, 0, 0, 0, 0, 32'h0,         32'h0,                 0, 32'h0,         32'h0,              32'h0,         0, 0);
        add(1, 0, 0, 0, 0, 32'h0,         32'h0,                 1, 32'h0,         32'h0,              32'h0,         0, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'h0 ^ K,             1, 32'h4,         32'h0 ^ K,          32'h0,         1, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'h4 ^ K,             1, 32'h8,         32'h4 ^ K,          32'h4,         1, 0);
        add(1, 1, 0, 0, 1, 32'h0,         32'h8 ^ K,             0, 32'h0,         32'h4 ^ K,          32'h4,         1, 0);
        add(1, 1, 0, 0, 0, 32'h0,         32'h0,                 0, 32'h0,         32'h4 ^ K,          32'h4,         1, 0);
        add(1, 0, 0, 0, 0, 32'h0,         32'h0,                 1, 32'hC,         32'h8 ^ K,          32'h8,         1, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'hC ^ K,             1, 32'h10,        32'hC ^ K,          32'hC,         1, 0);
        add(1, 0, 1, 0, 0, 32'h103,       32'h0,                 1, 32'h10,        32'h0,              32'h0,         0, 1);
        add(1, 0, 0, 0, 0, 32'h0,         32'h0,                 1, 32'h10,        32'h0,              32'h0,         0, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'h10 ^ K,            1, 32'h100,       32'h0,              32'h0,         0, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'h100 ^ K,           1, 32'h104,       32'h100 ^ K,        32'h100,       1, 0);
        add(1, 0, 1, 1, 0, 32'h200,       32'h0,                 1, 32'h104,       32'h0,              32'h0,         0, 1);
        add(1, 0, 0, 0, 1, 32'h0,         32'h104 ^ K,           1, 32'h80,        32'h0,              32'h0,         0, 0);
        add(1, 0, 0, 0, 1, 32'h0,         32'h80 ^ K,            1, 32'h84,        32'h80 ^ K,         32'h80,        1, 0);
        add(1, 0, 1, 0, 1, 32'h40,        32'h84 ^ K,            1, 32'h40,        32'h0,              32'h0,         0, 1);
        add(1, 0, 0, 0, 1, 32'h0,         32'h40 ^ K,            1, 32'h44,        32'h40 ^ K,         32'h40,        1, 0);
        add(1, 1, 0, 0, 0, 32'h0,         32'h0,                 1, 32'h44,        32'h40 ^ K,         32'h40,        1, 0);
        add(1, 1, 1, 0, 0, 32'h1000,      32'h0,                 1, 32'h44,        32'h0,              32'h0,         0, 1);
        add(1, 0, 1, 0, 0, 32'h2000,      32'h0,                 1, 32'h44,        32'h0,              32'h0,         0, 1);
        add(1, 0, 0, 0, 1, 32'h0,         32'h44 ^ K,            1, 32'h2000,      32'h0,              32'h0,         0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while draining: outstanding request abandoned, stray ack ignored in IDLE.
        seq(1, 1, 0, 32'h300,      32'h0,               1, 32'h2000,     32'h0,              32'h0,         0, 1, "drain_enter");
        seq(0, 0, 1, 32'h0,        32'h2000 ^ K,        0, 32'h0,        32'h0,              32'h0,         0, 0, "drain_reset");
        seq(1, 0, 1, 32'h0,        32'hDEAD_BEEF,       1, 32'h0,        32'h0,              32'h0,         0, 0, "stray_ack");
        seq(1, 0, 1, 32'h0,        32'h0 ^ K,           1, 32'h4,        32'h0 ^ K,          32'h0,         1, 0, "post_reset_fetch");

        // PC wraps from the top of the address space to zero.
        seq(1, 1, 1, 32'hFFFF_FFFE, 32'h4 ^ K,          1, 32'hFFFF_FFFC, 32'h0,             32'h0,         0, 1, "redirect_top");
        seq(1, 0, 1, 32'h0,        32'hFFFF_FFFC ^ K,   1, 32'h0,        32'hFFFF_FFFC ^ K,  32'hFFFF_FFFC, 1, 0, "pc_wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080: PC loaded on trap redirect.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 hazard_in  input  1  downstream stall; the current output instruction is not consumed this cycle.
REQ-006 branch_taken_in  input  1  branch/jump redirect request.
REQ-007 branch_target_in  input  32  redirect target address.
REQ-008 trap_in  input  1  trap redirect request to TRAP_VECTOR.
REQ-009 imem_req_out  output  1  instruction-memory request.
REQ-010 imem_addr_out  output  32  request address; stable while imem_req_out=1 and imem_ack_in=0.
REQ-011 imem_ack_in  input  1  memory returns data this cycle.
REQ-012 imem_rdata_in  input  32  instruction word, valid when imem_ack_in=1.
REQ-013 instrn_out  output  32  instruction word presented to the fetch stage.
REQ-014 pc_out  output  32  address of instrn_out.
REQ-015 valid_out  output  1  instrn_out/pc_out hold a real instruction; 0 means bubble.
REQ-016 flush_out  output  1  one-cycle pulse to the fetch stage on every redirect.

Function
REQ-017 The block SHALL implement four states: IDLE, FETCH, HOLD, DRAIN, all registered.
REQ-018 IDLE: imem_req_out=0; next state is always FETCH.
REQ-019 FETCH: imem_req_out=1, imem_addr_out=pc.
REQ-020 The output register (instrn_out, pc_out, valid_out) SHALL be loadable when hazard_in=0 or valid_out=0, and SHALL hold its value otherwise.
REQ-021 FETCH with ack and output loadable: load {rdata, pc, 1}, set pc <= pc+4, and stay in FETCH, giving a back-to-back fetch with one instruction per ack.
REQ-022 FETCH with ack and output not loadable: store {rdata, pc} in the skid register, set pc <= pc+4, and go to HOLD.
REQ-023 FETCH without ack and output loadable: load bubble {0, 0, 0}.
REQ-024 HOLD: imem_req_out=0; when the output is loadable, load from the skid register, then go to FETCH.
REQ-025 Redirect: trap_in has priority over branch_taken_in; the target is TRAP_VECTOR or {branch_target_in[31:2], 2'b00}.
REQ-026 On a redirect in any non-IDLE state, the block SHALL:
- set pc to the target;
- load the output register with bubble regardless of hazard_in;
- invalidate the skid register;
- assert flush_out for exactly the next cycle.
REQ-027 A redirect in FETCH while the request is unacked SHALL go to DRAIN, since the memory transaction cannot be withdrawn.
REQ-028 A redirect in the same cycle as an ack SHALL discard that data and stay in or return to FETCH at the target.
REQ-029 DRAIN: imem_req_out=1 with the old address held; the acked data is discarded; on ack go to FETCH at pc.
REQ-030 A further redirect during DRAIN SHALL overwrite pc with the latest target (last wins) and SHALL stay in DRAIN until the ack arrives.
REQ-031 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-032 A redirect in IDLE SHALL be ignored.

Reset
REQ-033 While reset_n=0 at a clock edge, the block SHALL set:
- pc=RESET_VECTOR and state=IDLE;
- imem_req_out=0 and imem_addr_out=0;
- instrn_out=0, pc_out=0, valid_out=0, flush_out=0;
- skid register invalid.
REQ-034 A reset mid-transaction SHALL abandon the outstanding request, and a late ack SHALL be ignored in IDLE.

Verification
REQ-035 Reset, then ack every cycle with rdata=addr^32'hA5A5_A5A5 -> pc_out sequence 0, 4, 8, ... with valid_out=1 from the third cycle.
REQ-036 hazard_in=1 while the ack for addr 8 arrives -> state HOLD, imem_req_out=0, outputs hold addr 4; release hazard -> pc_out=8, then the fetch of addr 12 is issued.
REQ-037 branch_taken_in=1 with target 32'h0000_0103 while the request for 16 is unacked -> flush_out pulses, DRAIN holds address 16 until ack, that data is dropped, then the fetch starts at 32'h0000_0100.
REQ-038 trap_in=1 and branch_taken_in=1 in the same cycle -> pc=32'h0000_0080, one flush_out pulse.
REQ-039 PC at 32'hFFFF_FFFC is acked -> next imem_addr_out=0.
REQ-040 reset_n=0 during DRAIN -> IDLE next cycle, all outputs 0, and a stray ack has no effect.
